// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider (div / divu).
// Operands are captured on an accepted start, converted to magnitudes in a
// one-cycle prep step, divided one quotient bit per RUN cycle, sign-fixed in
// FIX, and published on entry to DONE.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             DIVctrl,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // captured request
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;
    logic             uns_cap;

    // working registers
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             neg_q;
    logic             neg_r;

    // combinational datapath
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is honoured only in IDLE and DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = PREP;
            PREP: state_next = (b_cap == '0) ? DONE : RUN;
            RUN:  if (cnt == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = start ? PREP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, FIX: busy = 1'b1;
            DONE:     done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Magnitudes, trial subtract (WIDTH+1 bits) and final sign fix-up
    always_comb begin
        a_neg   = !uns_cap && a_cap[WIDTH-1];
        b_neg   = !uns_cap && b_cap[WIDTH-1];
        a_mag   = a_neg ? -a_cap : a_cap;
        b_mag   = b_neg ? -b_cap : b_cap;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;
    end

    // Capture, iterate and publish results; outputs change only on DONE entry
    always_ff @(posedge clk) begin
        if (reset) begin
            a_cap     <= '0;
            b_cap     <= '0;
            uns_cap   <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quo       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            divByZero <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_cap   <= busA;
                        b_cap   <= busB;
                        uns_cap <= DIVctrl;
                    end
                end
                PREP: begin
                    quo   <= a_mag;
                    rem   <= '0;
                    dvs   <= b_mag;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= CW'(WIDTH - 1);
                    if (b_cap == '0) begin
                        quotient  <= '1;
                        remainder <= a_cap;
                        divByZero <= 1'b1;
                    end
                end
                RUN: begin
                    // restoring step: keep the trial only when it did not borrow
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                    end
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    divByZero <= 1'b0;
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and random div/divu operations checked against
// a plain-arithmetic reference model, including latency, busy duration,
// ignored starts, back-to-back starts and mid-operation reset.
module tb_iter_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         DIVctrl;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .DIVctrl   (DIVctrl),
        .busA      (busA),
        .busB      (busB),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating division from plain integer arithmetic
    task automatic model(input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            if (uns) begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            dz = 1'b0;
        end
    endtask

    // One operation: drive at negedge, accepted at next posedge (E0),
    // then sample #1 after every edge until done. poke=1 fires a stray
    // start during RUN which must be ignored.
    task automatic run_op(input string tag, input logic uns, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           n;
        int           busy_cnt;
        bit           got;
        model(uns, a, b, eq, er, edz);
        @(negedge clk);
        start   = 1'b1;
        DIVctrl = uns;
        busA    = a;
        busB    = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busA    = $urandom;
        busB    = $urandom;
        DIVctrl = $urandom_range(0, 1);
        n = 0;
        busy_cnt = 0;
        got = 0;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
            if (done) got = 1;
            if (poke && n == 5) begin
                start   = 1'b1;
                DIVctrl = 1'b1;
                busA    = 32'd9;
                busB    = 32'd3;
            end else if (poke && n == 6) begin
                start = 1'b0;
            end
        end
        check({tag, ".latency"}, 64'(n), (b == 0) ? 64'd1 : 64'(W + 2));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), (b == 0) ? 64'd0 : 64'(W + 1));
        check({tag, ".quotient"}, 64'(quotient), 64'(eq));
        check({tag, ".remainder"}, 64'(remainder), 64'(er));
        check({tag, ".divByZero"}, 64'(divByZero), 64'(edz));
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    int           sel;
    int           n_rst;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        DIVctrl = 1'b0;
        busA    = '0;
        busB    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.divByZero", 64'(divByZero), 64'd0);
        reset = 1'b0;

        // directed cases; consecutive calls start in the DONE cycle
        run_op("divu_100_7", 1'b1, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
        run_op("divu_5_0", 1'b1, 32'd5, 32'd0, 1'b0);
        run_op("div_7_m2", 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_m7_m2", 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        run_op("div_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_ignore", 1'b1, 32'd100, 32'd7, 1'b1);

        // results hold after the done pulse
        hq = quotient;
        hr = remainder;
        repeat (3) @(posedge clk);
        #1;
        check("hold.done", 64'(done), 64'd0);
        check("hold.quotient", 64'(quotient), 64'(hq));
        check("hold.remainder", 64'(remainder), 64'(hr));

        // reset in the middle of RUN aborts the operation
        @(negedge clk);
        start   = 1'b1;
        DIVctrl = 1'b1;
        busA    = 32'd100;
        busB    = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_rst = 0;
        while (n_rst < 10) begin
            @(posedge clk);
            #1;
            n_rst++;
        end
        check("midrun.busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.quotient", 64'(quotient), 64'd0);
        check("abort.remainder", 64'(remainder), 64'd0);
        run_op("after_reset", 1'b0, 32'd1000, 32'd33, 1'b0);

        // random operations with biased divisors
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                3, 4:    rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
